// File: rtl/eth_mdio_phy_resp.sv
// eth_mdio_phy_resp: Clause 22 MDIO responder (PHY side).
// It decodes management frames from MDIO_I and holds a 32 x 16-bit register file.
// Reads are answered on MDIO_O/MDIO_Oe and writes are committed to the register file.
// Everything runs on the rising edge of the MDC clock (Clk).
//
// Every frame, including one for another PHY, ends at edge E18.
// E0 is the edge that samples the last REGAD bit.
//
// Register map:
//   reg 0    : bits 14:0 are writable and bit 15 always reads 0.
//              Writing bit 15 = 1 clears regs 0 and 4..31 one cycle after the commit.
//   regs 1-3 : read-only constants (STATUS_VAL, PHY_ID1, PHY_ID2).
//   regs 4-31: plain read/write storage.
module eth_mdio_phy_resp #(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter logic [15:0] PHY_ID1    = 16'h0007,
  parameter logic [15:0] PHY_ID2    = 16'hC0F1,
  parameter logic [15:0] STATUS_VAL = 16'h782D
) (
  input  logic Clk,
  input  logic Rst,
  input  logic MDIO_I,
  output logic MDIO_O,
  output logic MDIO_Oe,
  output logic Frame_Done,
  output logic Frame_Err,
  output logic Busy
);

  typedef enum logic [3:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RD_DATA, S_WR_DATA, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        is_rd_q, is_rd_d;
  logic        op_hi_q, op_hi_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] shift_q, shift_d;
  logic        o_q, o_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        soft_clr_q, soft_clr_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];

  // REGAD index as it stands once the bit being sampled is shifted in.
  logic [4:0]  rd_idx;
  logic [15:0] rd_val;
  // Register addressed by a write (address is complete long before data).
  logic [4:0]  wr_idx;
  logic [15:0] wr_val;

  assign rd_idx = {addr_q[3:0], MDIO_I};
  assign wr_idx = addr_q[4:0];
  assign wr_val = {shift_q[14:0], MDIO_I};

  // Read map: constants for regs 1-3, reg 0 bit 15 masked, rest from storage.
  always_comb begin
    rd_val = regs_q[rd_idx];
    case (rd_idx)
      5'd0:    rd_val = {1'b0, regs_q[0][14:0]};
      5'd1:    rd_val = STATUS_VAL;
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      default: ;
    endcase
  end

  // Frame decoder: next state, line drive, pulses and register file update.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = 6'd0;
    bit_cnt_d  = bit_cnt_q + 5'd1;
    is_rd_d    = is_rd_q;
    op_hi_d    = op_hi_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    o_d        = 1'b1;
    oe_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    soft_clr_d = 1'b0;
    regs_d     = regs_q;
    if (soft_clr_q) begin
      for (int i = 0; i < 32; i++) regs_d[i] = 16'h0000;
    end
    unique case (state_q)
      S_PRE: begin
        bit_cnt_d = 5'd0;
        if (MDIO_I) begin
          pre_cnt_d = (pre_cnt_q == 6'd32) ? pre_cnt_q : pre_cnt_q + 6'd1;
        end else if (pre_cnt_q == 6'd32) begin
          state_d = S_ST;
        end
      end
      S_ST: begin
        bit_cnt_d = 5'd0;
        if (MDIO_I) begin
          state_d = S_OP;
        end else begin
          err_d   = 1'b1;
          state_d = S_PRE;
        end
      end
      S_OP: begin
        if (bit_cnt_q == 5'd0) begin
          op_hi_d = MDIO_I;
        end else begin
          bit_cnt_d = 5'd0;
          if (op_hi_q != MDIO_I) begin
            is_rd_d = op_hi_q;
            state_d = S_PHYAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
      end
      S_PHYAD: begin
        addr_d = {addr_q[8:0], MDIO_I};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = S_REGAD;
        end
      end
      S_REGAD: begin
        addr_d = {addr_q[8:0], MDIO_I};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          if (addr_q[8:4] == PHY_ADDR) begin
            state_d = S_TA;
            shift_d = rd_val;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_TA: begin
        if (is_rd_q) begin
          oe_d = 1'b1;
          o_d  = (bit_cnt_q == 5'd0) ? 1'b0 : shift_q[15];
        end
        if (bit_cnt_q == 5'd1) begin
          bit_cnt_d = 5'd0;
          if (is_rd_q) begin
            state_d = S_RD_DATA;
            shift_d = {shift_q[14:0], 1'b0};
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end
      S_RD_DATA: begin
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = 5'd0;
          done_d    = 1'b1;
          state_d   = S_PRE;
        end else begin
          oe_d    = 1'b1;
          o_d     = shift_q[15];
          shift_d = {shift_q[14:0], 1'b0};
        end
      end
      S_WR_DATA: begin
        shift_d = wr_val;
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = 5'd0;
          done_d    = 1'b1;
          state_d   = S_PRE;
          if (wr_idx == 5'd0) begin
            regs_d[0]  = {1'b0, wr_val[14:0]};
            soft_clr_d = wr_val[15];
          end else if (wr_idx > 5'd3) begin
            regs_d[wr_idx] = wr_val;
          end
        end
      end
      S_SKIP: begin
        if (bit_cnt_q == 5'd17) begin
          bit_cnt_d = 5'd0;
          state_d   = S_PRE;
        end
      end
      default: state_d = S_PRE;
    endcase
  end

  // State and register file flops; reset aborts any frame in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_PRE;
      pre_cnt_q  <= 6'd0;
      bit_cnt_q  <= 5'd0;
      is_rd_q    <= 1'b0;
      op_hi_q    <= 1'b0;
      addr_q     <= 10'd0;
      shift_q    <= 16'h0000;
      o_q        <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      soft_clr_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      is_rd_q    <= is_rd_d;
      op_hi_q    <= op_hi_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      o_q        <= o_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      soft_clr_q <= soft_clr_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign MDIO_O     = o_q;
  assign MDIO_Oe    = oe_q;
  assign Frame_Done = done_q;
  assign Frame_Err  = err_q;
  assign Busy       = (state_q != S_PRE);

endmodule
